// File: rtl/mdu_pkg.sv
// Shared definitions for the M-extension sequencing controller:
// funct3 opcodes, controller states and small opcode/result helpers.
package mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        DIV_WAIT,
        RESP
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic div_signed(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic [1:0] mul_variant(input logic [2:0] op);
        return op[1:0];
    endfunction

    // Div entries pack {rem, quo}; mul entries hold the full product.
    function automatic logic [31:0] pick_result(input logic [2:0]  op,
                                                input logic [63:0] data);
        if (op[2])
            return op[1] ? data[63:32] : data[31:0];
        return (op == OP_MUL) ? data[31:0] : data[63:32];
    endfunction

endpackage

// File: rtl/mdu_seq_ctrl_if.sv
// Request/response handshake bundle between execute issue, the MD
// controller and the mem stage. master = issuing side, slave = controller.
interface mdu_seq_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_aluop;
    logic [31:0] req_opr1;
    logic [31:0] req_opr2;
    logic [4:0]  req_rdaddr;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_wdata;
    logic [4:0]  rsp_rdaddr;

    modport master (
        output req_valid, req_aluop, req_opr1, req_opr2, req_rdaddr,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid, rsp_wdata, rsp_rdaddr
    );

    modport slave (
        input  req_valid, req_aluop, req_opr1, req_opr2, req_rdaddr,
        input  rsp_ready,
        output req_ready,
        output rsp_valid, rsp_wdata, rsp_rdaddr
    );

endinterface

// File: rtl/mdu_result_cache.sv
// Single-entry last-result cache: stores operands, class, variant and the
// 64-bit product or {rem, quo}. Ports: clk/rst, clr (invalidate), write
// port wr_*, lookup port lk_* returning hit and the stored data.
module mdu_result_cache
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [2:0]  wr_op,
    input  logic [31:0] wr_opr1,
    input  logic [31:0] wr_opr2,
    input  logic [63:0] wr_data,
    input  logic [2:0]  lk_op,
    input  logic [31:0] lk_opr1,
    input  logic [31:0] lk_opr2,
    output logic        hit,
    output logic [63:0] rd_data
);

    logic        valid_q;
    logic        cls_div_q;
    logic [1:0]  var_q;
    logic [31:0] opr1_q;
    logic [31:0] opr2_q;
    logic [63:0] data_q;

    logic        same;
    logic        mul_hit;
    logic        div_hit;

    // Div entries only need signedness; keep it in var_q[0].
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid_q <= 1'b0;
        end else if (wr_en) begin
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            cls_div_q <= is_div(wr_op);
            var_q     <= is_div(wr_op) ? {1'b0, div_signed(wr_op)}
                                       : mul_variant(wr_op);
            opr1_q    <= wr_opr1;
            opr2_q    <= wr_opr2;
            data_q    <= wr_data;
        end
    end

    always_comb begin
        same    = valid_q && (opr1_q == lk_opr1) && (opr2_q == lk_opr2);
        // Low product word is signedness-independent, so MUL hits any
        // cached mul variant.
        mul_hit = same && !cls_div_q && !is_div(lk_op) &&
                  ((lk_op == OP_MUL) || (mul_variant(lk_op) == var_q));
        div_hit = same && cls_div_q && is_div(lk_op) &&
                  (var_q[0] == div_signed(lk_op));
        hit     = mul_hit || div_hit;
        rd_data = data_q;
    end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// MUL/DIV/REM sequencing controller: accepts ops, conditions operands,
// runs the external multiplier/divider and holds the result for mem.
// Ports: clk, cpurst, flush, bus (req/rsp handshake), mul_*, div_*, busy.
module mdu_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          cpurst,
    input  logic          flush,
    mdu_seq_ctrl_if.slave bus,
    output logic          mul_en,
    output logic [31:0]   mul_opr1,
    output logic [31:0]   mul_opr2,
    input  logic [63:0]   mul_prod,
    output logic          div_start,
    output logic          div_abort,
    output logic [31:0]   div_dividend,
    output logic [31:0]   div_divider,
    output logic          div_signed,
    input  logic [31:0]   div_quo,
    input  logic [31:0]   div_rem,
    input  logic          div_done,
    output logic          busy
);

    localparam logic [1:0] MC = 2'(MULT_CYCLES);

    state_t      state;
    state_t      state_nx;

    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  rd_q;
    logic [31:0] res_q;
    logic [1:0]  cnt;
    logic        first_q;

    logic        accept;
    logic        hit;
    logic [63:0] c_data;
    logic        mul_done;
    logic        div_fin;
    logic        neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] prod_fix;
    logic [63:0] wr_data;

    assign accept   = bus.req_valid && bus.req_ready;
    assign mul_done = (state == MUL_WAIT) && (cnt == MC);
    assign div_fin  = (state == DIV_WAIT) && div_done;
    assign wr_data  = mul_done ? prod_fix : {div_rem, div_quo};

    mdu_result_cache u_cache (
        .clk     (clk),
        .rst     (cpurst),
        .clr     (flush),
        .wr_en   (mul_done || div_fin),
        .wr_op   (op_q),
        .wr_opr1 (a_q),
        .wr_opr2 (b_q),
        .wr_data (wr_data),
        .lk_op   (bus.req_aluop),
        .lk_opr1 (bus.req_opr1),
        .lk_opr2 (bus.req_opr2),
        .hit     (hit),
        .rd_data (c_data)
    );

    always_ff @(posedge clk) begin
        if (cpurst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit)
                            state_nx = RESP;
                        else if (is_div(bus.req_aluop))
                            state_nx = DIV_WAIT;
                        else
                            state_nx = MUL_WAIT;
                    end
                end
                MUL_WAIT: if (mul_done) state_nx = RESP;
                DIV_WAIT: if (div_done) state_nx = RESP;
                RESP:     if (bus.rsp_ready) state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_ready  = (state == IDLE) && !flush;
        bus.rsp_valid  = 1'b0;
        bus.rsp_wdata  = '0;
        bus.rsp_rdaddr = '0;
        busy           = (state != IDLE);
        mul_en         = 1'b0;
        mul_opr1       = '0;
        mul_opr2       = '0;
        div_start      = 1'b0;
        div_abort      = 1'b0;
        div_dividend   = '0;
        div_divider    = '0;
        div_signed     = 1'b0;
        unique case (state)
            IDLE: ;
            MUL_WAIT: begin
                mul_en   = 1'b1;
                mul_opr1 = mag_a;
                mul_opr2 = mag_b;
            end
            DIV_WAIT: begin
                div_start    = first_q;
                div_abort    = flush;
                div_dividend = a_q;
                div_divider  = b_q;
                div_signed   = mdu_pkg::div_signed(op_q);
            end
            RESP: begin
                bus.rsp_valid  = 1'b1;
                bus.rsp_wdata  = res_q;
                bus.rsp_rdaddr = rd_q;
            end
        endcase
    end

    // Multiplier is unsigned; feed magnitudes and fix the sign afterwards.
    always_comb begin
        neg   = 1'b0;
        mag_a = a_q;
        mag_b = b_q;
        case (op_q)
            OP_MUL, OP_MULH: begin
                mag_a = a_q[31] ? (~a_q + 32'd1) : a_q;
                mag_b = b_q[31] ? (~b_q + 32'd1) : b_q;
                neg   = a_q[31] ^ b_q[31];
            end
            OP_MULHSU: begin
                mag_a = a_q[31] ? (~a_q + 32'd1) : a_q;
                neg   = a_q[31];
            end
            default: ;
        endcase
        prod_fix = neg ? (~mul_prod + 64'd1) : mul_prod;
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            cnt     <= '0;
            first_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= bus.req_aluop;
                a_q     <= bus.req_opr1;
                b_q     <= bus.req_opr2;
                rd_q    <= bus.req_rdaddr;
                cnt     <= '0;
                first_q <= 1'b1;
                if (hit)
                    res_q <= pick_result(bus.req_aluop, c_data);
            end
            if (state == MUL_WAIT)
                cnt <= cnt + 2'd1;
            if (state == DIV_WAIT)
                first_q <= 1'b0;
            if (mul_done)
                res_q <= pick_result(op_q, prod_fix);
            if (div_fin)
                res_q <= pick_result(op_q, {div_rem, div_quo});
        end
    end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed bench for mdu_seq_ctrl with behavioural multiplier and
// 33-cycle divider models; checks results, latency, cache hits, flush/reset.
module tb_mdu_seq_ctrl;

    localparam int MC = 1;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        flush;
    logic        mul_en;
    logic [31:0] mul_opr1;
    logic [31:0] mul_opr2;
    logic [63:0] mul_prod;
    logic        div_start;
    logic        div_abort;
    logic [31:0] div_dividend;
    logic [31:0] div_divider;
    logic        d_signed;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_done;
    logic        busy;

    int n_run  = 0;
    int n_fail = 0;

    mdu_seq_ctrl_if bus();

    mdu_seq_ctrl #(.MULT_CYCLES(MC)) dut (
        .clk          (clk),
        .cpurst       (cpurst),
        .flush        (flush),
        .bus          (bus),
        .mul_en       (mul_en),
        .mul_opr1     (mul_opr1),
        .mul_opr2     (mul_opr2),
        .mul_prod     (mul_prod),
        .div_start    (div_start),
        .div_abort    (div_abort),
        .div_dividend (div_dividend),
        .div_divider  (div_divider),
        .div_signed   (d_signed),
        .div_quo      (div_quo),
        .div_rem      (div_rem),
        .div_done     (div_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // One-stage multiplier: product valid one cycle after operands.
    always @(posedge clk) begin
        if (cpurst)
            mul_prod <= '0;
        else
            mul_prod <= {32'd0, mul_opr1} * {32'd0, mul_opr2};
    end

    logic        ign_abort = 1'b0;
    logic        dbusy     = 1'b0;
    int          dcnt      = 0;
    logic [31:0] dd;
    logic [31:0] dv;
    logic        ds;

    always @(posedge clk) begin
        div_done <= 1'b0;
        if (cpurst) begin
            dbusy   <= 1'b0;
            div_quo <= '0;
            div_rem <= '0;
        end else if (div_abort && !ign_abort) begin
            dbusy <= 1'b0;
        end else if (div_start) begin
            dbusy <= 1'b1;
            dcnt  <= 32;
            dd    <= div_dividend;
            dv    <= div_divider;
            ds    <= d_signed;
        end else if (dbusy) begin
            if (dcnt == 0) begin
                dbusy    <= 1'b0;
                div_done <= 1'b1;
                if (ds) begin
                    div_quo <= 32'($signed(dd) / $signed(dv));
                    div_rem <= 32'($signed(dd) % $signed(dv));
                end else begin
                    div_quo <= dd / dv;
                    div_rem <= dd % dv;
                end
            end else begin
                dcnt <= dcnt - 1;
            end
        end
    end

    int          n_mul   = 0;
    int          n_dst   = 0;
    int          n_abort = 0;
    logic [31:0] m1      = '0;
    logic [31:0] m2      = '0;
    logic        ds_seen = 1'b0;

    always @(posedge clk) begin
        if (mul_en) begin
            n_mul <= n_mul + 1;
            m1    <= mul_opr1;
            m2    <= mul_opr2;
        end
        if (div_start) begin
            n_dst   <= n_dst + 1;
            ds_seen <= d_signed;
        end
        if (div_abort)
            n_abort <= n_abort + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         output int lat, output int kdone);
        bus.req_valid  = 1'b1;
        bus.req_aluop  = op;
        bus.req_opr1   = a;
        bus.req_opr2   = b;
        bus.req_rdaddr = rd;
        #1;
        chk("req_ready", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        lat   = 0;
        kdone = 0;
        for (int k = 1; k <= 80; k++) begin
            if (div_done)
                kdone = k;
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
            tick();
        end
        if (lat == 0)
            chk("rsp_timeout", 0, 1);
    endtask

    // exp_lat <= 0 means a divider miss: response one cycle after done.
    task automatic run(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp,
                       input int exp_lat);
        int lat;
        int kd;
        issue(op, a, b, rd, lat, kd);
        chk({tag, "_data"}, bus.rsp_wdata, exp);
        chk({tag, "_rd"}, bus.rsp_rdaddr, rd);
        if (exp_lat > 0)
            chk({tag, "_lat"}, lat, exp_lat);
        else
            chk({tag, "_lat"}, lat, kd + 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int d0;
        int a0;
        int nv;
        int lat;
        int kd;

        bus.req_valid  = 1'b0;
        bus.req_aluop  = '0;
        bus.req_opr1   = '0;
        bus.req_opr2   = '0;
        bus.req_rdaddr = '0;
        bus.rsp_ready  = 1'b1;
        flush          = 1'b0;
        cpurst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cpurst = 1'b0;
        #1;

        chk("rst_ready", bus.req_ready, 1);
        chk("rst_ctl", {mul_en, div_start, div_abort, d_signed,
                        bus.rsp_valid, busy, bus.rsp_rdaddr}, 0);
        chk("rst_mulopr", {mul_opr1, mul_opr2}, 0);
        chk("rst_divopr", {div_dividend, div_divider}, 0);
        chk("rst_wdata", bus.rsp_wdata, 0);

        n0 = n_mul;
        run("mul", OP_MUL, 32'hFFFFFFFE, 32'h3, 5'd5, 32'hFFFFFFFA, 2 + MC);
        chk("mul_opr", {m1, m2}, {32'h2, 32'h3});
        chk("mul_en_cycles", n_mul - n0, MC + 1);

        run("mulh", OP_MULH, 32'hFFFFFFFE, 32'h3, 5'd6, 32'hFFFFFFFF, 2 + MC);
        n0 = n_mul;
        run("mul_hit", OP_MUL, 32'hFFFFFFFE, 32'h3, 5'd7, 32'hFFFFFFFA, 1);
        chk("mul_hit_no_en", n_mul - n0, 0);

        run("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,
            32'hFFFFFFFE, 2 + MC);
        chk("mulhu_opr", {m1, m2}, {32'hFFFFFFFF, 32'hFFFFFFFF});
        run("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,
            32'hFFFFFFFF, 2 + MC);
        chk("mulhsu_opr", {m1, m2}, {32'h1, 32'hFFFFFFFF});

        d0 = n_dst;
        run("div", OP_DIV, 32'hFFFFFFF9, 32'h2, 5'd10, 32'hFFFFFFFD, 0);
        chk("div_starts", n_dst - d0, 1);
        chk("div_signed", ds_seen, 1);
        d0 = n_dst;
        run("rem_hit", OP_REM, 32'hFFFFFFF9, 32'h2, 5'd11, 32'hFFFFFFFF, 1);
        chk("rem_hit_no_start", n_dst - d0, 0);
        run("remu", OP_REMU, 32'hFFFFFFF9, 32'h2, 5'd12, 32'h1, 0);
        chk("remu_starts", n_dst - d0, 1);
        chk("remu_unsigned", ds_seen, 0);

        bus.rsp_ready = 1'b0;
        issue(OP_DIVU, 32'hFFFFFFF9, 32'h2, 5'd13, lat, kd);
        chk("hold_lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_data", bus.rsp_wdata, 32'h7FFFFFFC);
            chk("hold_rd", bus.rsp_rdaddr, 13);
            chk("hold_req_ready", bus.req_ready, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("hold_release", bus.rsp_valid, 0);

        ign_abort      = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_aluop  = OP_DIV;
        bus.req_opr1   = 32'd100;
        bus.req_opr2   = 32'd7;
        bus.req_rdaddr = 5'd14;
        tick();
        bus.req_valid = 1'b0;
        chk("divw_busy", busy, 1);
        tick();
        tick();
        a0    = n_abort;
        flush = 1'b1;
        #1;
        chk("abort_pulse", div_abort, 1);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_idle", {busy, div_abort, bus.rsp_valid}, 0);
        chk("flush_ready", bus.req_ready, 1);
        chk("abort_once", n_abort - a0, 1);
        nv = 0;
        repeat (50) begin
            if (bus.rsp_valid)
                nv++;
            tick();
        end
        chk("late_done_ignored", nv, 0);
        ign_abort = 1'b0;

        d0 = n_dst;
        run("divu_after_flush", OP_DIVU, 32'hFFFFFFF9, 32'h2, 5'd15,
            32'h7FFFFFFC, 0);
        chk("flush_invalidates", n_dst - d0, 1);

        bus.req_valid  = 1'b1;
        bus.req_aluop  = OP_MUL;
        bus.req_opr1   = 32'd5;
        bus.req_opr2   = 32'd6;
        flush          = 1'b1;
        #1;
        chk("flush_beats_req", bus.req_ready, 0);
        tick();
        bus.req_valid = 1'b0;
        flush         = 1'b0;
        #1;
        chk("flush_no_accept", busy, 0);

        run("mul_pre", OP_MUL, 32'hFFFFFFFE, 32'h3, 5'd16, 32'hFFFFFFFA,
            2 + MC);
        bus.req_valid  = 1'b1;
        bus.req_aluop  = OP_MULH;
        bus.req_opr1   = 32'hFFFFFFFE;
        bus.req_opr2   = 32'h3;
        bus.req_rdaddr = 5'd17;
        tick();
        bus.req_valid = 1'b0;
        chk("rst_mid_mulen", mul_en, 1);
        cpurst = 1'b1;
        tick();
        cpurst = 1'b0;
        #1;
        chk("rstm_ready", bus.req_ready, 1);
        chk("rstm_ctl", {mul_en, div_start, div_abort, d_signed,
                         bus.rsp_valid, busy, bus.rsp_rdaddr}, 0);
        chk("rstm_mulopr", {mul_opr1, mul_opr2}, 0);
        chk("rstm_divopr", {div_dividend, div_divider}, 0);
        chk("rstm_wdata", bus.rsp_wdata, 0);
        n0 = n_mul;
        run("mul_after_rst", OP_MUL, 32'hFFFFFFFE, 32'h3, 5'd18,
            32'hFFFFFFFA, 2 + MC);
        chk("rst_recompute", n_mul - n0, MC + 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
